data_mem_ctrl: RTL

Parametrised data-memory controller for the pipeline's MEM stage. It supports byte, half and word accesses, with sign- or zero-extended loads and per-lane byte-strobe writes. Reads are synchronous and use a valid/ready handshake; misaligned accesses are flagged rather than silently dropped. It also provides a read-only debug port for the debug unit, and after every reset it clears the whole array with an init sweep.

---
 rtl/data_mem_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: byte/half/word loads and stores, one-cycle response,
// read-first debug port, and a zero-fill sweep of the array after every reset.
module data_mem_ctrl #(
  parameter int NB_DATA  = 32,
  parameter int N_WORDS  = 64,
  parameter int NB_ADDR  = $clog2(N_WORDS*NB_DATA/8),
  parameter int NB_WADDR = $clog2(N_WORDS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [1:0]          i_req_size,
  input  logic                i_req_unsigned,
  input  logic [NB_ADDR-1:0]  i_req_addr,
  input  logic [31:0]         i_req_wdata,
  output logic                o_rsp_valid,
  output logic [31:0]         o_rsp_rdata,
  output logic                o_rsp_err,
  input  logic                i_dbg_en,
  input  logic [NB_WADDR-1:0] i_dbg_addr,
  output logic                o_dbg_valid,
  output logic [NB_DATA-1:0]  o_dbg_data,
  output logic                o_init_busy
);

  localparam int LANES  = NB_DATA/8;
  localparam int NB_OFF = $clog2(LANES);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t              state, state_nxt;
  logic [NB_WADDR-1:0] cnt, cnt_nxt;
  logic [NB_DATA-1:0]  mem [N_WORDS];

  function automatic logic req_err(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return (a != 2'b00);
      2'b01:   return a[0];
      2'b11:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size,
                                                 input logic [NB_OFF-1:0] off);
    logic [LANES-1:0] base;
    base = '0;
    case (size)
      2'b00:   base[3:0] = 4'hF;
      2'b01:   base[1:0] = 2'h3;
      default: base[0]   = 1'b1;
    endcase
    return base << off;
  endfunction

  // Lanes are shifted down to bit 0 first, so every size extracts from the low bytes.
  function automatic logic [31:0] load_ext(input logic [NB_DATA-1:0] word,
                                           input logic [NB_OFF-1:0]  off,
                                           input logic [1:0]         size,
                                           input logic               uns);
    logic [NB_DATA-1:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   return sh[31:0];
      2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      2'b11:   return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    o_req_ready = 1'b0;
    o_init_busy = 1'b0;
    case (state)
      ST_INIT: begin
        o_init_busy = 1'b1;
        cnt_nxt     = cnt + 1'b1;
        if (cnt == NB_WADDR'(N_WORDS-1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: o_req_ready = 1'b1;
    endcase
  end

  // Stage p0: request decode
  logic                accept_p0, err_p0, wr_en_p0;
  logic [NB_OFF-1:0]   off_p0;
  logic [NB_WADDR-1:0] widx_p0;
  logic [LANES-1:0]    be_p0;
  logic [NB_DATA-1:0]  wdata_p0;

  assign accept_p0 = i_req_valid & o_req_ready;
  assign off_p0    = i_req_addr[NB_OFF-1:0];
  assign widx_p0   = i_req_addr[NB_ADDR-1:NB_OFF];
  assign err_p0    = req_err(i_req_size, i_req_addr[1:0]);
  assign be_p0     = lane_mask(i_req_size, off_p0);
  assign wdata_p0  = NB_DATA'(i_req_wdata) << {off_p0, 3'b000};
  assign wr_en_p0  = accept_p0 & i_req_we & ~err_p0 & i_rst_n;

  always_ff @(posedge i_clk) begin
    if (o_init_busy) begin
      mem[cnt] <= '0;
    end else if (wr_en_p0) begin
      for (int l = 0; l < LANES; l++)
        if (be_p0[l]) mem[widx_p0][l*8 +: 8] <= wdata_p0[l*8 +: 8];
    end
  end

  // Stage p1: registered response and debug read
  logic        vld_p1, err_p1, dbg_vld_p1;
  logic [31:0] rdata_p1;
  logic [NB_DATA-1:0] dbg_data_p1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_p1      <= 1'b0;
      err_p1      <= 1'b0;
      rdata_p1    <= '0;
      dbg_vld_p1  <= 1'b0;
      dbg_data_p1 <= '0;
    end else begin
      vld_p1     <= accept_p0;
      dbg_vld_p1 <= i_dbg_en & ~o_init_busy;
      if (accept_p0) begin
        err_p1   <= err_p0;
        rdata_p1 <= (err_p0 | i_req_we) ? 32'h0
                    : load_ext(mem[widx_p0], off_p0, i_req_size, i_req_unsigned);
      end
      if (i_dbg_en & ~o_init_busy) dbg_data_p1 <= mem[i_dbg_addr];
    end
  end

  // A response pending while reset is asserted is dropped, not shown for a cycle.
  assign o_rsp_valid = vld_p1 & i_rst_n;
  assign o_rsp_rdata = rdata_p1;
  assign o_rsp_err   = err_p1;
  assign o_dbg_valid = dbg_vld_p1;
  assign o_dbg_data  = dbg_data_p1;

endmodule
